soc_clock_reset_ctrl: RTL

Clock-enable and reset sequencer that sits between the board clock/reset pins and `Grande_Risco_5_SOC`. It divides the board clock into a single-cycle enable and a toggled divided clock. It holds the SoC in reset for a programmed number of enabled cycles after power-up or a soft-reset request, then releases it synchronously. It replaces the ad-hoc divider flop in the board tops and adds a debounced soft-reset path (button, watchdog or UART break).

---
 rtl/soc_clkrst_pkg.sv | 11 +
 rtl/reset_debouncer.sv | 59 +++++
 rtl/soc_clock_reset_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/soc_clkrst_pkg.sv
// Shared types and constants for the SoC clock-enable / reset sequencer.
package soc_clkrst_pkg;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int SOFT_RESET_COUNT_W = 8;

endpackage

// File: rtl/reset_debouncer.sv
// Synchronizes and debounces an async soft-reset level into a single-cycle pulse.
// Pulse lands DEBOUNCE_CYCLES+1 clk after the first sampled high; no backpressure, one pulse per held request.
module reset_debouncer
  import soc_clkrst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_async,
  output logic req_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            done_q, done_d;
  logic            pulse_q, pulse_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    sync1_d  = req_async;
    sync2_d  = sync1_q;
    db_cnt_d = db_cnt_q;
    done_d   = done_q;
    pulse_d  = 1'b0;
    if (!sync2_q) begin
      db_cnt_d = '0;
      done_d   = 1'b0;
    end else if (db_cnt_q == DB_LAST) begin
      // counter parks at its terminal value; done blocks re-firing until the input drops
      pulse_d = ~done_q;
      done_d  = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      done_q   <= 1'b0;
      pulse_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      done_q   <= done_d;
      pulse_q  <= pulse_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign req_pulse = pulse_q;

endmodule

// File: rtl/soc_clock_reset_ctrl.sv
// Board clock divider plus SoC reset sequencer with debounced soft-reset and a saturating event count.
// Release after RESET_HOLD*CLK_DIV+1 clk from power-up; soft reset asserts DEBOUNCE_CYCLES+2 clk after request; no backpressure.
module soc_clock_reset_ctrl
  import soc_clkrst_pkg::*;
#(
  parameter int CLK_DIV         = 1,
  parameter int RESET_HOLD      = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          CPU_RESETN,
  input  logic                          soft_reset_req,
  output logic                          clk_en,
  output logic                          clk_div,
  output logic                          soc_reset,
  output logic                          ready,
  output logic [SOFT_RESET_COUNT_W-1:0] soft_reset_count
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  state_e                          state_q, state_d;
  logic [DIV_W-1:0]                div_cnt_q, div_cnt_d;
  logic [HOLD_W-1:0]               hold_cnt_q, hold_cnt_d;
  logic                            clk_en_q, clk_en_d;
  logic                            clk_div_q, clk_div_d;
  logic [SOFT_RESET_COUNT_W-1:0]   count_q, count_d;
  logic                            req_pulse;

  reset_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst_n    (CPU_RESETN),
    .req_async(soft_reset_req),
    .req_pulse(req_pulse)
  );

  always_comb begin
    clk_en_d  = (div_cnt_q == DIV_LAST);
    div_cnt_d = clk_en_d ? '0 : div_cnt_q + 1'b1;
    clk_div_d = clk_div_q ^ clk_en_d;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    count_d    = count_q;
    unique case (state_q)
      ST_HOLD: begin
        // a fresh request restarts the hold window, even on the completion edge
        if (req_pulse) begin
          hold_cnt_d = '0;
        end else if (clk_en_q) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (req_pulse) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          if (count_q != '1) count_d = count_q + 1'b1;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q    <= ST_HOLD;
      div_cnt_q  <= '0;
      hold_cnt_q <= '0;
      clk_en_q   <= 1'b0;
      clk_div_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      clk_en_q   <= clk_en_d;
      clk_div_q  <= clk_div_d;
      count_q    <= count_d;
    end
  end

  assign clk_en           = clk_en_q;
  assign clk_div          = clk_div_q;
  assign soc_reset        = (state_q == ST_HOLD);
  assign ready            = (state_q == ST_RUN);
  assign soft_reset_count = count_q;

endmodule
